// File: rtl/rk4_tx_arbiter_if.sv
// Frame-request and uart_tx handshake bundle for rk4_tx_arbiter.
// master = requesters plus uart_tx side, slave = the arbiter.
interface rk4_tx_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BYTES = 8,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*LEN_W-1:0]       req_len;
  logic [NUM_REQ*8*MAX_BYTES-1:0] req_data;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             done;
  logic                           busy;
  logic                           tx_ready;
  logic                           tx_valid;
  logic [7:0]                     tx_data;

  modport master (
    output req, req_len, req_data, tx_ready,
    input  grant, done, busy, tx_valid, tx_data
  );

  modport slave (
    input  req, req_len, req_data, tx_ready,
    output grant, done, busy, tx_valid, tx_data
  );
endinterface

// File: rtl/rk4_tx_arbiter.sv
// rk4_tx_arbiter: shares one byte-wide uart_tx between NUM_REQ frame sources, one whole frame per grant.
// Define RK4_TX_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
//
// state    | meaning
// IDLE     | no owner; arbitrate among unmasked requests
// LOAD     | latch winner's frame and clamped length
// SEND     | strobe next byte once uart_tx is ready
// WAIT_ACK | wait for uart_tx to drop tx_ready (byte taken)
// FIN      | pulse done, release grant, advance pointer
module rk4_tx_arbiter #(
  parameter int  NUM_REQ   = 2,
  parameter int  MAX_BYTES = 8,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  rk4_tx_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FRM_W = 8 * MAX_BYTES;
  localparam logic [IDX_W:0]   NUM_REQ_V = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_ACK, FIN} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [FRM_W-1:0]   shift_q, shift_d;
  logic [LEN_W-1:0]   bytes_left_q, bytes_left_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mask_q, mask_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   base;
  logic [LEN_W-1:0]   len_sel, len_clamped;
  logic [FRM_W-1:0]   data_sel;

`ifdef RK4_TX_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign base = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == FIN) ptr_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  // Search order starts at base; the requester just served sits out the first IDLE cycle after FIN.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, base} + (IDX_W + 1)'(k);
      if (sum >= NUM_REQ_V) sum = sum - NUM_REQ_V;
      cand = sum[IDX_W-1:0];
      if (!win_found && bus.req[cand] && !(mask_q && cand == idx_q)) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign len_sel     = bus.req_len[int'(idx_q) * LEN_W +: LEN_W];
  assign data_sel    = bus.req_data[int'(idx_q) * FRM_W +: FRM_W];
  assign len_clamped = (len_sel > MAX_LEN) ? MAX_LEN : len_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      shift_q      <= '0;
      bytes_left_q <= '0;
      idx_q        <= '0;
      mask_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      shift_q      <= shift_d;
      bytes_left_q <= bytes_left_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (win_found) state_d = LOAD;
      LOAD:     state_d = (len_clamped == '0) ? FIN : SEND;
      SEND:     if (bus.tx_ready) state_d = WAIT_ACK;
      WAIT_ACK: if (!bus.tx_ready) state_d = (bytes_left_q != '0) ? SEND : FIN;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    done_d       = '0;
    busy_d       = (state_d != IDLE);
    tx_valid_d   = 1'b0;
    tx_data_d    = tx_data_q;
    shift_d      = shift_q;
    bytes_left_d = bytes_left_q;
    idx_d        = idx_q;
    mask_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = NUM_REQ'(1) << win_idx;
          idx_d   = win_idx;
        end
      end
      LOAD: begin
        shift_d      = data_sel;
        bytes_left_d = len_clamped;
      end
      SEND: begin
        if (bus.tx_ready) begin
          tx_valid_d   = 1'b1;
          tx_data_d    = shift_q[7:0];
          shift_d      = shift_q >> 8;
          bytes_left_d = bytes_left_q - 1'b1;
        end
      end
      FIN: begin
        done_d  = grant_q;
        grant_d = '0;
        mask_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
endmodule
